ysyx_22050133_mem_arb: RTL and testbench

YSYX_22050133_MEM_ARB -- requirements
Module: ysyx_22050133_mem_arb

---
 rtl/ysyx_22050133_mem_arb.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_22050133_mem_arb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_mem_arb.sv
// Two-master (IFU/LSU) arbiter in front of a single-outstanding memory port.
// LSU has priority; a starvation counter forces an IFU grant after STARVE_MAX LSU wins.
`timescale 1ns/1ps
module ysyx_22050133_mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // IFU
  input  logic        if_req_valid,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [63:0] if_rdata,
  // LSU
  input  logic        ls_req_valid,
  input  logic        ls_wen,
  input  logic [31:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_req_ready,
  output logic        ls_rsp_valid,
  output logic [63:0] ls_rdata,
  // memory
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  // status
  output logic        busy
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;      // 0 = IFU, 1 = LSU
  logic [CW-1:0] starve_q, starve_d;
  logic          drop_q, drop_d;
  logic [31:0]   addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic          if_rsp_q, if_rsp_d;
  logic          ls_rsp_q, ls_rsp_d;
  logic [63:0]   if_rdata_q, if_rdata_d;
  logic [63:0]   ls_rdata_q, ls_rdata_d;

  logic starve_hit;
  logic grant_ls;
  logic grant_if;
  logic rsp_fire;
  logic drop_now;

  assign starve_hit = (starve_q == CW'(STARVE_MAX));
  assign grant_ls   = (state_q == S_IDLE) && ls_req_valid && !(if_req_valid && starve_hit);
  assign grant_if   = (state_q == S_IDLE) && if_req_valid && !grant_ls;
  assign rsp_fire   = (state_q == S_WAIT) && mem_rsp_valid;
  // A flush arriving in the same cycle as the response must still suppress it.
  assign drop_now   = drop_q || (if_flush && !owner_q && (state_q != S_IDLE));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output is assigned a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_ls || grant_if) state_d = S_REQ;
      S_REQ:   if (mem_req_ready)        state_d = S_WAIT;
      S_WAIT:  if (mem_rsp_valid)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    mem_req_valid = (state_q == S_REQ);
    if_req_ready  = grant_if;
    ls_req_ready  = grant_ls;
  end

  always_comb begin
    owner_d    = owner_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_rsp_d   = 1'b0;
    ls_rsp_d   = 1'b0;
    drop_d     = (state_d == S_IDLE) ? 1'b0 : drop_now;

    if (grant_if) begin
      starve_d = '0;
    end else if (grant_ls && if_req_valid) begin
      if (!starve_hit) starve_d = starve_q + CW'(1);
    end else if ((state_q == S_IDLE) && !if_req_valid) begin
      starve_d = '0;
    end

    if (grant_ls) begin
      owner_d = 1'b1;
      addr_d  = ls_addr;
      wen_d   = ls_wen;
      wdata_d = ls_wdata;
      wmask_d = ls_wmask;
    end else if (grant_if) begin
      owner_d = 1'b0;
      addr_d  = if_addr;
      wen_d   = 1'b0;
      wdata_d = '0;
      wmask_d = 8'h00;
    end

    if (rsp_fire) begin
      if (owner_q) begin
        ls_rsp_d   = 1'b1;
        ls_rdata_d = mem_rdata;
      end else if (!drop_now) begin
        if_rsp_d   = 1'b1;
        if_rdata_d = mem_rdata;
      end
    end
  end

  // NOTE: all control and datapath flops are reset, so outputs are defined the
  // instant rst rises, even mid-transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= 1'b0;
      starve_q   <= '0;
      drop_q     <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_rsp_q   <= 1'b0;
      ls_rsp_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      drop_q     <= drop_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      if_rsp_q   <= if_rsp_d;
      ls_rsp_q   <= ls_rsp_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wen      = wen_q;
  assign mem_wdata    = wdata_q;
  assign mem_wmask    = wmask_q;
  assign if_rsp_valid = if_rsp_q;
  assign ls_rsp_valid = ls_rsp_q;
  assign if_rdata     = if_rdata_q;
  assign ls_rdata     = ls_rdata_q;

endmodule

// File: tb/tb_ysyx_22050133_mem_arb.sv
// Directed bench for ysyx_22050133_mem_arb: inputs driven and outputs sampled around
// the falling edge; expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_ysyx_22050133_mem_arb;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [63:0] if_rdata;
  logic        ls_req_valid;
  logic        ls_wen;
  logic [31:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [63:0] ls_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        busy;

  int vectors;
  int miscompares;

  localparam logic [63:0] RD_S = 64'h1111_2222_3333_4444;

  ysyx_22050133_mem_arb #(.STARVE_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_addr       (if_addr),
    .if_flush      (if_flush),
    .if_req_ready  (if_req_ready),
    .if_rsp_valid  (if_rsp_valid),
    .if_rdata      (if_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_wen        (ls_wen),
    .ls_addr       (ls_addr),
    .ls_wdata      (ls_wdata),
    .ls_wmask      (ls_wmask),
    .ls_req_ready  (ls_req_ready),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rdata      (ls_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One IFU fetch with immediate memory; flush bits: [2] grant cycle, [1] WAIT, [0] REQ.
  task automatic ifu_fetch(input logic [31:0] addr, input logic [63:0] rdata, input logic [2:0] flush,
                           input logic exp_pulse, input logic [63:0] exp_rdata, input string tag);
    @(negedge clk);
    if_req_valid = 1'b1;
    if_addr      = addr;
    if_flush     = flush[2];
    #1;
    check({tag, "_if_rdy"}, if_req_ready, 1'b1);
    check({tag, "_ls_rdy"}, ls_req_ready, 1'b0);
    @(negedge clk);
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    if_flush      = flush[0];
    #1;
    check({tag, "_req_valid"}, mem_req_valid, 1'b1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_wen"}, mem_wen, 1'b0);
    check({tag, "_wmask"}, mem_wmask, 8'h00);
    check({tag, "_wdata"}, mem_wdata, 64'h0);
    check({tag, "_busy_req"}, busy, 1'b1);
    check({tag, "_if_rdy_req"}, if_req_ready, 1'b0);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = rdata;
    if_flush      = flush[1];
    #1;
    check({tag, "_req_valid_wait"}, mem_req_valid, 1'b0);
    check({tag, "_rsp_early"}, if_rsp_valid, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    if_flush      = 1'b0;
    #1;
    check({tag, "_rsp_pulse"}, if_rsp_valid, exp_pulse);
    check({tag, "_rdata"}, if_rdata, exp_rdata);
    check({tag, "_busy_after"}, busy, 1'b0);
    @(negedge clk);
    #1;
    check({tag, "_rsp_end"}, if_rsp_valid, 1'b0);
    check({tag, "_rdata_hold"}, if_rdata, exp_rdata);
  endtask

  initial begin
    logic exp_if;
    logic prev_if;
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    if_req_valid  = 1'b0;
    if_addr       = '0;
    if_flush      = 1'b0;
    ls_req_valid  = 1'b0;
    ls_wen        = 1'b0;
    ls_addr       = '0;
    ls_wdata      = '0;
    ls_wmask      = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wen", mem_wen, 1'b0);
    check("rst_if_rsp", if_rsp_valid, 1'b0);
    check("rst_if_rdata", if_rdata, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic fetch, first request right after reset
    ifu_fetch(32'h8000_0000, 64'h0000_0000_0010_0073, 3'b000, 1'b1, 64'h0000_0000_0010_0073, "fetch");

    // Both request continuously: LSU x4 then IFU, repeating
    @(negedge clk);
    if_req_valid  = 1'b1;
    if_addr       = 32'h8000_0004;
    ls_req_valid  = 1'b1;
    ls_wen        = 1'b0;
    ls_addr       = 32'h8000_0100;
    ls_wdata      = 64'h0;
    ls_wmask      = 8'hFF;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = RD_S;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) repeat (3) @(negedge clk);
      #1;
      exp_if = (i % 5 == 4);
      check("starve_if_rdy", if_req_ready, exp_if);
      check("starve_ls_rdy", ls_req_ready, !exp_if);
      if (i > 0) begin
        prev_if = ((i - 1) % 5 == 4);
        check("starve_if_rsp", if_rsp_valid, prev_if);
        check("starve_ls_rsp", ls_rsp_valid, !prev_if);
      end
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("starve_last_if_rsp", if_rsp_valid, 1'b1);
    check("starve_last_if_rdata", if_rdata, RD_S);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;

    // LSU store held in REQ for 5 cycles; IFU flush must not affect it
    @(negedge clk);
    ls_req_valid = 1'b1;
    ls_wen       = 1'b1;
    ls_addr      = 32'h8000_1000;
    ls_wdata     = 64'hDEAD_BEEF_0000_0001;
    ls_wmask     = 8'h0F;
    #1;
    check("st_ls_rdy", ls_req_ready, 1'b1);
    check("st_if_rdy", if_req_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        ls_req_valid = 1'b0;
        ls_wen       = 1'b0;
        ls_addr      = 32'h0;
        ls_wdata     = '1;
        ls_wmask     = 8'hF0;
        if_flush     = 1'b1;
      end
      #1;
      check("st_req_valid", mem_req_valid, 1'b1);
      check("st_addr", mem_addr, 32'h8000_1000);
      check("st_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0001);
      check("st_wmask", mem_wmask, 8'h0F);
      check("st_wen", mem_wen, 1'b1);
    end
    @(negedge clk);
    mem_req_ready = 1'b1;
    if_flush      = 1'b0;
    #1;
    check("st_req_valid_acc", mem_req_valid, 1'b1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h0000_0000_0000_CAFE;
    #1;
    check("st_busy_wait", busy, 1'b1);
    check("st_rsp_early", ls_rsp_valid, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    check("st_rsp_pulse", ls_rsp_valid, 1'b1);
    check("st_rdata", ls_rdata, 64'h0000_0000_0000_CAFE);
    check("st_busy_after", busy, 1'b0);
    @(negedge clk);
    #1;
    check("st_rsp_end", ls_rsp_valid, 1'b0);

    // Flushed fetches are dropped; an IDLE-cycle flush is ignored
    ifu_fetch(32'h8000_0008, 64'h0000_0000_0000_BAD1, 3'b010, 1'b0, RD_S, "flush_wait");
    ifu_fetch(32'h8000_0010, 64'h0000_0000_0000_BAD2, 3'b001, 1'b0, RD_S, "flush_req");
    ifu_fetch(32'h8000_0018, 64'h0000_0000_0000_600D, 3'b100, 1'b1, 64'h0000_0000_0000_600D, "flush_idle");

    // Asynchronous reset in the middle of a WAIT
    @(negedge clk);
    ls_req_valid = 1'b1;
    ls_wen       = 1'b1;
    ls_addr      = 32'h8000_3000;
    ls_wdata     = 64'h0123_4567_89AB_CDEF;
    ls_wmask     = 8'hFF;
    @(negedge clk);
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check("ar_req_valid", mem_req_valid, 1'b1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    check("ar_busy_wait", busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_busy", busy, 1'b0);
    check("ar_mem_req_valid", mem_req_valid, 1'b0);
    check("ar_mem_wen", mem_wen, 1'b0);
    check("ar_mem_addr", mem_addr, 32'h0);
    check("ar_mem_wdata", mem_wdata, 64'h0);
    check("ar_mem_wmask", mem_wmask, 8'h00);
    check("ar_if_rdata", if_rdata, 64'h0);
    check("ar_ls_rdata", ls_rdata, 64'h0);
    check("ar_ls_rsp", ls_rsp_valid, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h0000_0000_0000_DEAD;
    #1;
    check("ar_stale_busy", busy, 1'b0);
    @(negedge clk);
    rst          = 1'b0;
    ls_req_valid = 1'b1;
    ls_wen       = 1'b0;
    ls_addr      = 32'h8000_2000;
    #1;
    check("ar_first_ls_rdy", ls_req_ready, 1'b1);
    check("ar_stale_ls_rsp", ls_rsp_valid, 1'b0);
    @(negedge clk);
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    check("ar_stale_ls_rsp2", ls_rsp_valid, 1'b0);
    check("ar_new_req_valid", mem_req_valid, 1'b1);
    check("ar_new_addr", mem_addr, 32'h8000_2000);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h0000_0000_0000_5A5A;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    check("ar_new_rsp", ls_rsp_valid, 1'b1);
    check("ar_new_rdata", ls_rdata, 64'h0000_0000_0000_5A5A);

    // Response while IDLE is ignored
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("idle_rsp_busy0", busy, 1'b0);
    @(negedge clk);
    #1;
    check("idle_rsp_if", if_rsp_valid, 1'b0);
    check("idle_rsp_ls", ls_rsp_valid, 1'b0);
    check("idle_rsp_busy", busy, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    check("idle_rsp_if2", if_rsp_valid, 1'b0);
    check("idle_rsp_ls2", ls_rsp_valid, 1'b0);
    check("idle_ls_rdata", ls_rdata, 64'h0000_0000_0000_5A5A);
    check("idle_if_rdata", if_rdata, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
